mainmenu_input_controller: RTL and testbench

Main-menu cursor controller: the writer of the menu-selection metadata field that the VGA main-menu renderer reads to place its selection box. Synchronises and edge-detects the five raw menu buttons, moves a cursor over the five-option two-column menu, and on select issues a one-cycle start command with the chosen mode. The controller then locks until the game reports completion. Sits between the button inputs and the metadata register / game-mode sequencer.

---
 rtl/mainmenu_pkg.sv | 68 ++++++
 rtl/btn_sync_edge.sv | 34 +++
 rtl/mainmenu_input_controller.sv | 149 ++++++++++++++
 tb/tb_mainmenu_input_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mainmenu_pkg.sv
// Shared encodings and cursor-move functions for the main-menu controller.
package mainmenu_pkg;

   localparam logic [2:0] OPT_PLAY1P  = 3'd0;
   localparam logic [2:0] OPT_ENDLESS = 3'd1;
   localparam logic [2:0] OPT_PLAY2P  = 3'd2;
   localparam logic [2:0] OPT_TOP1P   = 3'd3;
   localparam logic [2:0] OPT_TOPEND  = 3'd4;

   localparam int unsigned NUM_BTN    = 5;
   localparam int unsigned BTN_UP     = 0;
   localparam int unsigned BTN_DOWN   = 1;
   localparam int unsigned BTN_LEFT   = 2;
   localparam int unsigned BTN_RIGHT  = 3;
   localparam int unsigned BTN_SELECT = 4;

   typedef enum logic [1:0] {StMenu, StStart, StLocked} menu_state_e;

   function automatic logic [2:0] step_up(input logic [2:0] s);
      logic [2:0] r;
      case (s)
         OPT_PLAY1P:  r = OPT_PLAY2P;
         OPT_ENDLESS: r = OPT_PLAY1P;
         OPT_PLAY2P:  r = OPT_ENDLESS;
         OPT_TOP1P:   r = OPT_TOPEND;
         OPT_TOPEND:  r = OPT_TOP1P;
         default:     r = OPT_PLAY1P;
      endcase
      return r;
   endfunction

   function automatic logic [2:0] step_down(input logic [2:0] s);
      logic [2:0] r;
      case (s)
         OPT_PLAY1P:  r = OPT_ENDLESS;
         OPT_ENDLESS: r = OPT_PLAY2P;
         OPT_PLAY2P:  r = OPT_PLAY1P;
         OPT_TOP1P:   r = OPT_TOPEND;
         OPT_TOPEND:  r = OPT_TOP1P;
         default:     r = OPT_PLAY1P;
      endcase
      return r;
   endfunction

   function automatic logic [2:0] step_left(input logic [2:0] s);
      logic [2:0] r;
      case (s)
         OPT_PLAY1P, OPT_ENDLESS, OPT_PLAY2P: r = s;
         OPT_TOP1P:  r = OPT_PLAY1P;
         OPT_TOPEND: r = OPT_ENDLESS;
         default:    r = OPT_PLAY1P;
      endcase
      return r;
   endfunction

   function automatic logic [2:0] step_right(input logic [2:0] s);
      logic [2:0] r;
      case (s)
         OPT_PLAY1P:             r = OPT_TOP1P;
         OPT_ENDLESS:            r = OPT_TOPEND;
         OPT_PLAY2P:             r = OPT_TOPEND;
         OPT_TOP1P, OPT_TOPEND:  r = s;
         default:                r = OPT_PLAY1P;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for one raw button input.
module btn_sync_edge (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);

   logic       meta_q;
   logic       sync_q;
   logic       prev_q;
   logic [2:0] fill_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         fill_q <= '0;
      end else begin
         meta_q <= raw;
         sync_q <= meta_q;
         prev_q <= sync_q;
         fill_q <= {fill_q[1:0], 1'b1};
      end
   end

   // prev_q holds a real post-reset sample only once fill_q is full, so a
   // button held through reset is not mistaken for a fresh press.
   assign level = sync_q;
   assign press = sync_q & ~prev_q & fill_q[2];

endmodule

// File: rtl/mainmenu_input_controller.sv
// Main-menu cursor controller: button sync/edge, cursor moves, start/lock FSM.
// Optional feature macro: MENU_AUTOREPEAT_EN (up/down auto-repeat while held).
module mainmenu_input_controller
   import mainmenu_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY = 25_000_000,
   parameter int unsigned REPEAT_RATE  = 6_250_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_select,
   input  logic       game_done,
   output logic [2:0] sel,
   output logic       start,
   output logic [2:0] mode,
   output logic       menu_active
);

   logic [NUM_BTN-1:0] raw;
   logic [NUM_BTN-1:0] level;
   logic [NUM_BTN-1:0] press;

   menu_state_e state_q, state_d;
   logic [2:0]  sel_q, sel_d;
   logic [2:0]  mode_q, mode_d;
   logic        start_q;
   logic        rep_step;
   logic        rep_up;

   assign raw = {btn_select, btn_right, btn_left, btn_down, btn_up};

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_sync_edge u_btn (
         .clock(clock),
         .reset(reset),
         .raw  (raw[i]),
         .level(level[i]),
         .press(press[i])
      );
   end

`ifdef MENU_AUTOREPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned CNT_W   = $clog2(REP_MAX + 1);

   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [CNT_W-1:0] rep_thr;
   logic             rep_first_q, rep_first_d;
   logic             rep_up_q, rep_up_d;
   logic             rep_held;
   logic             unused_levels;

   assign rep_thr       = rep_first_q ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_RATE);
   assign rep_held      = rep_up_q ? level[BTN_UP] : level[BTN_DOWN];
   assign rep_up        = rep_up_q;
   assign unused_levels = ^level[BTN_SELECT:BTN_LEFT];

   // A non-zero count means a repeat run is armed; anything else drops it.
   always_comb begin
      rep_cnt_d   = '0;
      rep_first_d = rep_first_q;
      rep_up_d    = rep_up_q;
      rep_step    = 1'b0;
      if (state_q == StMenu && !press[BTN_SELECT]) begin
         if (press[BTN_UP] || press[BTN_DOWN]) begin
            rep_cnt_d   = CNT_W'(1);
            rep_first_d = 1'b1;
            rep_up_d    = press[BTN_UP];
         end else if (press == '0 && rep_cnt_q != '0 && rep_held) begin
            if (rep_cnt_q == rep_thr) begin
               rep_step    = 1'b1;
               rep_cnt_d   = CNT_W'(1);
               rep_first_d = 1'b0;
            end else begin
               rep_cnt_d = rep_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rep_cnt_q   <= '0;
         rep_first_q <= 1'b0;
         rep_up_q    <= 1'b0;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_first_q <= rep_first_d;
         rep_up_q    <= rep_up_d;
      end
   end
`else
   logic unused_levels;
   assign unused_levels = ^{level, REPEAT_DELAY, REPEAT_RATE};
   assign rep_step      = 1'b0;
   assign rep_up        = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      mode_d  = mode_q;
      unique case (state_q)
         StMenu: begin
            if (press[BTN_SELECT]) begin
               mode_d  = sel_q;
               state_d = StStart;
            end else if (press[BTN_UP]) begin
               sel_d = step_up(sel_q);
            end else if (press[BTN_DOWN]) begin
               sel_d = step_down(sel_q);
            end else if (press[BTN_LEFT]) begin
               sel_d = step_left(sel_q);
            end else if (press[BTN_RIGHT]) begin
               sel_d = step_right(sel_q);
            end else if (rep_step) begin
               sel_d = rep_up ? step_up(sel_q) : step_down(sel_q);
            end
         end
         StStart:  state_d = StLocked;
         StLocked: if (game_done) state_d = StMenu;
         default:  state_d = StMenu;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StMenu;
         sel_q   <= OPT_PLAY1P;
         mode_q  <= OPT_PLAY1P;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         mode_q  <= mode_d;
         start_q <= (state_d == StStart);
      end
   end

   assign sel         = sel_q;
   assign mode        = mode_q;
   assign start       = start_q;
   assign menu_active = (state_q == StMenu);

endmodule

// File: tb/tb_mainmenu_input_controller.sv
// Randomised bench for mainmenu_input_controller against a behavioural menu model.
module tb_mainmenu_input_controller;

   localparam int RD = 8;
   localparam int RR = 4;
`ifdef MENU_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] btns = '0;  // 0 up, 1 down, 2 left, 3 right, 4 select
   logic       game_done = 1'b0;
   logic [2:0] sel;
   logic [2:0] mode;
   logic       start;
   logic       menu_active;

   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   mainmenu_input_controller #(
      .REPEAT_DELAY(RD),
      .REPEAT_RATE (RR)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .btn_up     (btns[0]),
      .btn_down   (btns[1]),
      .btn_left   (btns[2]),
      .btn_right  (btns[3]),
      .btn_select (btns[4]),
      .game_done  (game_done),
      .sel        (sel),
      .start      (start),
      .mode       (mode),
      .menu_active(menu_active)
   );

   // Menu layout as lookup tables indexed by current option.
   int up_tab[5]    = '{2, 0, 1, 4, 3};
   int down_tab[5]  = '{1, 2, 0, 4, 3};
   int left_tab[5]  = '{0, 1, 2, 0, 1};
   int right_tab[5] = '{3, 4, 4, 3, 4};

   int m_sel = 0;
   int m_mode = 0;
   int m_phase = 0;  // 0 menu, 1 start pulse, 2 locked
   int rep_btn = -1;
   int rep_since = 0;
   logic [2:0] hist[5];  // raw samples at past edges, bit0 newest
   logic [2:0] hv[5];    // whether each sample was taken out of reset
   logic [4:0] m_pr;
   logic [4:0] m_lv;

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // A press acts two edges after the level is first sampled, and only on a
   // 0->1 change between two samples taken after reset.
   task automatic model_step();
      if (reset) begin
         m_sel = 0; m_mode = 0; m_phase = 0; rep_btn = -1; rep_since = 0;
         for (int b = 0; b < 5; b++) begin
            hist[b] = '0;
            hv[b]   = '0;
         end
      end else begin
         for (int b = 0; b < 5; b++) begin
            m_pr[b] = hist[b][1] & ~hist[b][2] & hv[b][2];
            m_lv[b] = hist[b][1];
         end
         case (m_phase)
            0: begin
               if (m_pr[4]) begin
                  m_mode = m_sel; m_phase = 1; rep_btn = -1;
               end else if (m_pr[0]) begin
                  m_sel = up_tab[m_sel]; rep_btn = 0; rep_since = 0;
               end else if (m_pr[1]) begin
                  m_sel = down_tab[m_sel]; rep_btn = 1; rep_since = 0;
               end else if (m_pr[2]) begin
                  m_sel = left_tab[m_sel]; rep_btn = -1;
               end else if (m_pr[3]) begin
                  m_sel = right_tab[m_sel]; rep_btn = -1;
               end else if (AR && rep_btn >= 0 && m_lv[rep_btn]) begin
                  rep_since++;
                  if (rep_since == RD || (rep_since > RD && (rep_since - RD) % RR == 0))
                     m_sel = (rep_btn == 0) ? up_tab[m_sel] : down_tab[m_sel];
               end else begin
                  rep_btn = -1;
               end
            end
            1: begin
               m_phase = 2; rep_btn = -1;
            end
            default: begin
               if (game_done) m_phase = 0;
               rep_btn = -1;
            end
         endcase
         for (int b = 0; b < 5; b++) begin
            hist[b] = {hist[b][1:0], btns[b]};
            hv[b]   = {hv[b][1:0], 1'b1};
         end
      end
   endtask

   initial forever begin
      @(posedge clock);
      model_step();
   end

   always @(negedge clock) begin
      check("sel", 8'(sel), 8'(m_sel));
      check("mode", 8'(mode), 8'(m_mode));
      check("start", 8'(start), 8'(m_phase == 1));
      check("menu_active", 8'(menu_active), 8'(m_phase == 0));
   end

   task automatic pulse(input int b, input int hold, input int gap);
      btns[b] = 1'b1;
      repeat (hold) @(negedge clock);
      btns[b] = 1'b0;
      repeat (gap) @(negedge clock);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("rst_sel", 8'(sel), 8'd0);
      check("rst_mode", 8'(mode), 8'd0);
      check("rst_start", 8'(start), 8'd0);
      check("rst_menu_active", 8'(menu_active), 8'd1);

      pulse(1, 10, 10); check("down1", 8'(sel), 8'd1);
      pulse(1, 10, 10); check("down2", 8'(sel), 8'd2);
      pulse(1, 10, 10); check("down3_wrap", 8'(sel), 8'd0);
      pulse(1, 10, 10); pulse(1, 10, 10);
      pulse(3, 10, 10); check("right_2_to_4", 8'(sel), 8'd4);
      pulse(2, 10, 10); check("left_4_to_1", 8'(sel), 8'd1);
      pulse(2, 10, 10); check("left_col0_stay", 8'(sel), 8'd1);
      pulse(3, 10, 10); pulse(0, 10, 10);
      check("up_4_to_3", 8'(sel), 8'd3);

      btns[4] = 1'b1;
      repeat (2) @(negedge clock);
      check("sel_start_early", 8'(start), 8'd0);
      @(negedge clock);
      check("sel_start_pulse", 8'(start), 8'd1);
      check("sel_mode", 8'(mode), 8'd3);
      check("sel_menu_off", 8'(menu_active), 8'd0);
      @(negedge clock);
      check("sel_start_once", 8'(start), 8'd0);
      repeat (6) @(negedge clock);
      btns[4] = 1'b0;
      repeat (10) @(negedge clock);
      pulse(0, 5, 5); pulse(0, 5, 5);
      check("locked_sel", 8'(sel), 8'd3);
      check("locked_menu_off", 8'(menu_active), 8'd0);
      game_done = 1'b1;
      @(negedge clock);
      game_done = 1'b0;
      check("unlock_menu_on", 8'(menu_active), 8'd1);
      check("unlock_sel_kept", 8'(sel), 8'd3);

      pulse(2, 10, 10); check("left_3_to_0", 8'(sel), 8'd0);
      btns = 5'b10001;
      repeat (3) @(negedge clock);
      check("both_start", 8'(start), 8'd1);
      check("both_mode", 8'(mode), 8'd0);
      check("both_sel", 8'(sel), 8'd0);
      repeat (7) @(negedge clock);
      btns = '0;
      repeat (10) @(negedge clock);

      btns[1] = 1'b1;
      repeat (5) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (15) @(negedge clock);
      check("held_rst_sel", 8'(sel), 8'd0);
      check("held_rst_menu", 8'(menu_active), 8'd1);
      btns[1] = 1'b0;
      repeat (10) @(negedge clock);
      check("held_rst_still0", 8'(sel), 8'd0);
      pulse(1, 10, 10); check("repress_down", 8'(sel), 8'd1);

      pulse(0, 10, 10); check("up_1_to_0", 8'(sel), 8'd0);
      btns[1] = 1'b1;
      repeat (3) @(negedge clock);
      check("hold_first_step", 8'(sel), 8'd1);
      repeat (8) @(negedge clock);
      check("hold_delay_step", 8'(sel), AR ? 8'd2 : 8'd1);
      repeat (9) @(negedge clock);
      btns[1] = 1'b0;
      repeat (10) @(negedge clock);
      check("hold_final", 8'(sel), 8'd1);

      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < 5; b++)
            if ($urandom_range(7) == 0) btns[b] = ~btns[b];
         game_done = ($urandom_range(15) == 0);
         reset     = ($urandom_range(299) == 0);
         @(negedge clock);
      end
      btns = '0; game_done = 1'b0; reset = 1'b0;
      repeat (10) @(negedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
